uart_line_buffer: RTL and testbench

Line-assembly stage between the on-chip UART receive port and the downstream character processor that feeds the UART transmit port. Accepts ASCII bytes over ready/valid and stores them in a local buffer. Applies backspace editing, then releases the whole line in order once a line terminator arrives or the buffer fills. Echo/processing logic therefore sees complete, edited lines rather than raw keystrokes.

---
 rtl/uart_line_buffer.sv | 132 +++++++++++++
 tb/tb_uart_line_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_buffer.sv
// ============================================================================
// Module   : uart_line_buffer
// Brief    : Collects UART receive bytes into a line with backspace editing and
//            releases the whole line downstream on a terminator or when full.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_line_buffer #(
    parameter int          DEPTH    = 64,
    parameter logic [7:0]  EOL_CHAR = 8'h0D,
    parameter logic [7:0]  BS_CHAR  = 8'h08
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [7:0]               line_count,
    output logic                     truncated
);

    localparam int        AW     = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
    localparam logic [7:0]  C_DEL  = 8'h7F;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     fill_q, fill_d;
    logic [7:0]      lcnt_q, lcnt_d;
    logic            trunc_q, trunc_d;
    logic            wr_en;

    logic w_is_bs;
    logic w_is_eol;

    assign w_is_bs  = (in_data == BS_CHAR) || (in_data == C_DEL);
    assign w_is_eol = (in_data == EOL_CHAR);

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        lcnt_d    = lcnt_q;
        trunc_d   = 1'b0;
        wr_en     = 1'b0;
        in_ready  = (state_q == S_FILL);
        out_valid = (state_q == S_DRAIN);

        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    if (w_is_bs) begin
                        // Backspace on an empty line is silently dropped
                        if (fill_q != '0) begin
                            wr_ptr_d = wr_ptr_q - 1'b1;
                            fill_d   = fill_q - 1'b1;
                        end
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        fill_d   = fill_q + 1'b1;
                        if (w_is_eol) begin
                            state_d = S_DRAIN;
                        end else if (fill_q == C_FULL - 1'b1) begin
                            state_d = S_DRAIN;
                            trunc_d = 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    fill_d   = fill_q - 1'b1;
                    if (fill_q == (AW+1)'(1)) begin
                        state_d  = S_FILL;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        lcnt_d   = lcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            lcnt_q   <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            lcnt_q   <= lcnt_d;
            trunc_q  <= trunc_d;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_data   = mem_q[rd_ptr_q];
    assign fill_level = fill_q;
    assign line_count = lcnt_q;
    assign truncated  = trunc_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_line_buffer.sv
// ============================================================================
// Module   : tb_uart_line_buffer
// Brief    : Directed scoreboard bench for uart_line_buffer (DEPTH=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_line_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] fill_level;
    logic [7:0] line_count;
    logic       truncated;

    int checks = 0;
    int failures = 0;
    int lc_exp = 0;

    logic [7:0] line_q[$];
    logic [7:0] exp_q[$];

    uart_line_buffer #(.DEPTH(DEPTH), .EOL_CHAR(8'h0D), .BS_CHAR(8'h08)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level),
        .line_count (line_count),
        .truncated  (truncated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one byte and updates the line model; completed lines go to the scoreboard
    task automatic send(input logic [7:0] b);
        int w = 0;
        bit done_line = 1'b0;
        while (in_ready !== 1'b1 && w < 64) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 64) chk("send_timeout", {31'b0, in_ready}, 32'd1);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (b == 8'h08 || b == 8'h7F) begin
            if (line_q.size() > 0) void'(line_q.pop_back());
        end else begin
            line_q.push_back(b);
            if (b == 8'h0D || line_q.size() == DEPTH) begin
                foreach (line_q[i]) exp_q.push_back(line_q[i]);
                line_q.delete();
                done_line = 1'b1;
            end
        end
        if (done_line) begin
            chk("first_out_latency", {31'b0, out_valid}, 32'd1);
            chk("truncated_pulse", {31'b0, truncated}, {31'b0, b != 8'h0D});
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    // Pulls up to nmax bytes; toggle=1 uses out_ready pattern 1,0,0,1,0,0,...
    task automatic drain(input int nmax, input bit toggle);
        int cyc = 0;
        int done = 0;
        bit stalled = 1'b0;
        logic [7:0] hold = 8'h00;
        logic [7:0] e;
        while (done < nmax && exp_q.size() > 0 && cyc < 64) begin
            out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
            if (stalled) chk("stall_hold_data", {24'b0, out_data}, {24'b0, hold});
            chk("drain_out_valid", {31'b0, out_valid}, 32'd1);
            chk("drain_in_ready", {31'b0, in_ready}, 32'd0);
            if (out_ready) begin
                e = exp_q.pop_front();
                chk("out_data", {24'b0, out_data}, {24'b0, e});
                done++;
                stalled = 1'b0;
            end else begin
                hold = out_data;
                stalled = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (cyc >= 64) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic drain_line(input bit toggle);
        drain(1000, toggle);
        lc_exp++;
        chk("post_line_count", {24'b0, line_count}, lc_exp);
        chk("post_in_ready", {31'b0, in_ready}, 32'd1);
        chk("post_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_fill", {29'b0, fill_level}, 32'd0);
    endtask

    initial begin
        // Reset
        #2;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_fill", {29'b0, fill_level}, 32'd0);
        chk("rst_line_count", {24'b0, line_count}, 32'd0);
        chk("rst_truncated", {31'b0, truncated}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // "ab" CR
        send_str("ab");
        chk("fill_ab", {29'b0, fill_level}, 32'd2);
        send(8'h0D);
        chk("drain_in_ready_low", {31'b0, in_ready}, 32'd0);
        drain_line(1'b0);

        // "abc" BS DEL "x" CR
        send_str("abc");
        chk("fill_peak", {29'b0, fill_level}, 32'd3);
        send(8'h08);
        send(8'h7F);
        chk("fill_after_bs", {29'b0, fill_level}, 32'd1);
        send_str("x");
        send(8'h0D);
        drain_line(1'b0);

        // BS on empty then CR
        send(8'h08);
        chk("fill_empty_bs", {29'b0, fill_level}, 32'd0);
        send(8'h0D);
        drain_line(1'b0);

        // Truncation on full buffer, hold one stalled cycle first
        send_str("wxyz");
        @(posedge clk); #1;
        chk("truncated_one_cycle", {31'b0, truncated}, 32'd0);
        chk("trunc_hold_data", {24'b0, out_data}, 32'h77);
        drain_line(1'b0);
        send_str("q");
        send(8'h0D);
        drain_line(1'b0);

        // CR filling the buffer exactly: no truncation, toggled drain
        send_str("abc");
        send(8'h0D);
        drain_line(1'b1);

        // Reset mid-drain
        send_str("mn");
        send(8'h0D);
        drain(2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_fill", {29'b0, fill_level}, 32'd0);
        chk("mid_rst_line_count", {24'b0, line_count}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        exp_q.delete();
        line_q.delete();
        lc_exp = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_str("k");
        send(8'h0D);
        drain_line(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
